// File: rtl/io_map_pkg.sv
// io_map_pkg: register offsets, STATUS bit indices and address decode for dmem_io_responder.
package io_map_pkg;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0100;
    localparam logic [31:0] OFS_LED       = 32'h00;
    localparam logic [31:0] OFS_SW        = 32'h04;
    localparam logic [31:0] OFS_TCNT      = 32'h08;
    localparam logic [31:0] OFS_TCMP      = 32'h0C;
    localparam logic [31:0] OFS_STATUS    = 32'h10;
    localparam int ST_MATCH = 0;
    localparam int ST_SWCHG = 1;

    typedef enum logic [2:0] {R_LED, R_SW, R_TCNT, R_TCMP, R_STATUS, R_NONE} reg_sel_e;

    // Word-granular match: the byte lane bits of the address are ignored.
    function automatic logic hit(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] ofs);
        logic [31:0] t;
        t = base + ofs;
        return (addr >> 2) == (t >> 2);
    endfunction

    function automatic reg_sel_e decode(input logic [31:0] addr, input logic [31:0] base);
        return hit(addr, base, OFS_LED)    ? R_LED    :
               hit(addr, base, OFS_SW)     ? R_SW     :
               hit(addr, base, OFS_TCNT)   ? R_TCNT   :
               hit(addr, base, OFS_TCMP)   ? R_TCMP   :
               hit(addr, base, OFS_STATUS) ? R_STATUS : R_NONE;
    endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchronizer plus shared stability counter; emits accepted value and a change pulse.
module io_debounce
    import io_map_pkg::*;
#(
    parameter int          SW_WIDTH        = 8,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw_i,
    output logic [SW_WIDTH-1:0] stable_o,
    output logic                chg_o
);
    logic [SW_WIDTH-1:0] sync1_q, sync2_q, stable_q;
    logic [15:0]         cnt_q, cnt_d;

    assign chg_o    = (sync2_q != stable_q) && (cnt_q == DEBOUNCE_CYCLES - 16'd1);
    assign stable_o = stable_q;

    always_comb begin
        cnt_d = (sync2_q == stable_q || chg_o) ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            if (chg_o) stable_q <= sync2_q;
        end
    end
endmodule

// File: rtl/dmem_io_responder.sv
// dmem_io_responder: data-memory-mapped LED, debounced switches, timer/compare and W1C status flags.
module dmem_io_responder
    import io_map_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR,
    parameter int          SW_WIDTH        = 8,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dmem_wr,
    input  logic [31:0]         dmem_waddr,
    input  logic [31:0]         dmem_wdata,
    input  logic                dmem_rd,
    input  logic [31:0]         dmem_raddr,
    output logic [31:0]         dmem_rdata,
    input  logic [SW_WIDTH-1:0] sw_in,
    output logic [7:0]          leds,
    output logic                timer_match
);
    reg_sel_e            wsel, rsel;
    logic [7:0]          led_q, led_d;
    logic [31:0]         tcnt_q, tcnt_d, tcmp_q, tcmp_d, rdata_q, rdata_d;
    logic [1:0]          status_q, status_d, st_set, st_clr;
    logic [SW_WIDTH-1:0] sw_stable;
    logic                sw_chg;

    io_debounce #(.SW_WIDTH(SW_WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk      (clk),
        .rst      (rst),
        .sw_i     (sw_in),
        .stable_o (sw_stable),
        .chg_o    (sw_chg)
    );

    assign wsel = dmem_wr ? decode(dmem_waddr, BASE_ADDR) : R_NONE;
    assign rsel = decode(dmem_raddr, BASE_ADDR);

    // Reads use the _q values, so a same-cycle write is not visible to the read; set beats W1C.
    always_comb begin
        led_d              = wsel == R_LED  ? dmem_wdata[7:0] : led_q;
        tcnt_d             = wsel == R_TCNT ? dmem_wdata : tcnt_q + 32'd1;
        tcmp_d             = wsel == R_TCMP ? dmem_wdata : tcmp_q;
        st_set             = '0;
        st_set[ST_MATCH]   = tcnt_q == tcmp_q;
        st_set[ST_SWCHG]   = sw_chg;
        st_clr             = wsel == R_STATUS ? dmem_wdata[1:0] : 2'b00;
        status_d           = (status_q & ~st_clr) | st_set;
        rdata_d            = !dmem_rd           ? rdata_q            :
                             rsel == R_LED      ? {24'd0, led_q}     :
                             rsel == R_SW       ? 32'(sw_stable)     :
                             rsel == R_TCNT     ? tcnt_q             :
                             rsel == R_TCMP     ? tcmp_q             :
                             rsel == R_STATUS   ? {30'd0, status_q}  : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= '0;
            tcnt_q   <= '0;
            tcmp_q   <= '0;
            status_q <= '0;
            rdata_q  <= '0;
        end else begin
            led_q    <= led_d;
            tcnt_q   <= tcnt_d;
            tcmp_q   <= tcmp_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dmem_rdata  = rdata_q;
    assign leds        = led_q;
    assign timer_match = status_q[ST_MATCH];
endmodule

// File: tb/tb_dmem_io_responder.sv
// tb_dmem_io_responder: directed scenario tasks with hand-computed expectations for dmem_io_responder.
module tb_dmem_io_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        dmem_wr = 1'b0, dmem_rd = 1'b0;
    logic [31:0] dmem_waddr = '0, dmem_wdata = '0, dmem_raddr = '0;
    logic [31:0] dmem_rdata;
    logic [7:0]  sw_in = '0;
    logic [7:0]  leds;
    logic        timer_match;
    int          n_checks = 0, n_fail = 0;
    int unsigned cyc_since_rst = 0;

    dmem_io_responder #(.BASE_ADDR(32'h0000_0100), .SW_WIDTH(8), .DEBOUNCE_CYCLES(16'd4)) dut (
        .clk         (clk),
        .rst         (rst),
        .dmem_wr     (dmem_wr),
        .dmem_waddr  (dmem_waddr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rd     (dmem_rd),
        .dmem_raddr  (dmem_raddr),
        .dmem_rdata  (dmem_rdata),
        .sw_in       (sw_in),
        .leds        (leds),
        .timer_match (timer_match)
    );

    always #5 clk = ~clk;

    // Edge count since reset; equals the timer count until software writes TCNT.
    always @(posedge clk) cyc_since_rst <= rst ? 0 : cyc_since_rst + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                       input logic r, input logic [31:0] ra);
        dmem_wr = w; dmem_waddr = wa; dmem_wdata = wd;
        dmem_rd = r; dmem_raddr = ra;
        step();
        dmem_wr = 1'b0; dmem_rd = 1'b0;
    endtask

    task automatic test_reset();
        int unsigned e;
        rst = 1'b1;
        repeat (3) step();
        n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL rst_leds got %h exp 00", leds); end
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", dmem_rdata); end
        rst = 1'b0;
        bus(0, 0, 0, 1, 32'h100);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_led_rd got %h exp 0", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h104);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_sw_rd got %h exp 0", dmem_rdata); end
        e = cyc_since_rst;
        bus(0, 0, 0, 1, 32'h108);
        n_checks++; if (dmem_rdata !== e) begin n_fail++; $display("FAIL rst_tcnt_rd got %h exp %h", dmem_rdata, e); end
        bus(0, 0, 0, 1, 32'h10C);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_tcmp_rd got %h exp 0", dmem_rdata); end
        // Count 0 equals TCMP 0 on the first cycle out of reset, so MATCH is already set.
        bus(0, 0, 0, 1, 32'h110);
        n_checks++; if (dmem_rdata !== 32'h1) begin n_fail++; $display("FAIL rst_status_rd got %h exp 1", dmem_rdata); end
        bus(1, 32'h110, 32'h3, 0, 0);
        n_checks++; if (timer_match !== 1'b0) begin n_fail++; $display("FAIL rst_w1c got %b exp 0", timer_match); end
    endtask

    task automatic test_led();
        bus(1, 32'h100, 32'h0000_00A5, 0, 0);
        n_checks++; if (leds !== 8'hA5) begin n_fail++; $display("FAIL led_out got %h exp a5", leds); end
        bus(0, 0, 0, 1, 32'h100);
        n_checks++; if (dmem_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL led_rd got %h exp a5", dmem_rdata); end
        bus(1, 32'h103, 32'h1234_5611, 0, 0);
        n_checks++; if (leds !== 8'h11) begin n_fail++; $display("FAIL led_bytelane got %h exp 11", leds); end
        bus(0, 0, 0, 1, 32'h102);
        n_checks++; if (dmem_rdata !== 32'h0000_0011) begin n_fail++; $display("FAIL led_upper_rd got %h exp 11", dmem_rdata); end
    endtask

    task automatic test_same_cycle();
        bus(1, 32'h100, 32'h22, 1, 32'h100);
        n_checks++; if (dmem_rdata !== 32'h11) begin n_fail++; $display("FAIL rw_old got %h exp 11", dmem_rdata); end
        n_checks++; if (leds !== 8'h22) begin n_fail++; $display("FAIL rw_leds got %h exp 22", leds); end
    endtask

    task automatic test_glitch();
        sw_in = 8'hFF;
        repeat (2) step();
        sw_in = 8'h00;
        repeat (8) step();
        bus(0, 0, 0, 1, 32'h104);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL glitch_sw got %h exp 0", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h110);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL glitch_status got %h exp 0", dmem_rdata); end
    endtask

    task automatic test_debounce();
        sw_in = 8'h3C;
        repeat (5) step();
        bus(0, 0, 0, 1, 32'h104);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL deb_early got %h exp 0", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h104);
        n_checks++; if (dmem_rdata !== 32'h3C) begin n_fail++; $display("FAIL deb_sw got %h exp 3c", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h110);
        n_checks++; if (dmem_rdata !== 32'h2) begin n_fail++; $display("FAIL deb_status got %h exp 2", dmem_rdata); end
        bus(1, 32'h110, 32'h2, 0, 0);
        bus(0, 0, 0, 1, 32'h110);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL deb_w1c got %h exp 0", dmem_rdata); end
    endtask

    task automatic test_timer();
        bus(1, 32'h10C, 32'd10, 0, 0);
        bus(1, 32'h108, 32'd5, 0, 0);
        n_checks++; if (timer_match !== 1'b0) begin n_fail++; $display("FAIL tmr_pre got %b exp 0", timer_match); end
        repeat (5) step();
        n_checks++; if (timer_match !== 1'b0) begin n_fail++; $display("FAIL tmr_at10 got %b exp 0", timer_match); end
        step();
        n_checks++; if (timer_match !== 1'b1) begin n_fail++; $display("FAIL tmr_match got %b exp 1", timer_match); end
        bus(0, 0, 0, 1, 32'h110);
        n_checks++; if (dmem_rdata !== 32'h1) begin n_fail++; $display("FAIL tmr_status got %h exp 1", dmem_rdata); end
        bus(1, 32'h110, 32'h1, 0, 0);
        n_checks++; if (timer_match !== 1'b0) begin n_fail++; $display("FAIL tmr_w1c got %b exp 0", timer_match); end
        bus(1, 32'h108, 32'hFFFF_FFFF, 0, 0);
        bus(0, 0, 0, 1, 32'h108);
        n_checks++; if (dmem_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tmr_max got %h exp ffffffff", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h108);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL tmr_wrap got %h exp 0", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h10C);
        n_checks++; if (dmem_rdata !== 32'd10) begin n_fail++; $display("FAIL tmr_tcmp got %h exp a", dmem_rdata); end
    endtask

    task automatic test_w1c_race();
        bus(1, 32'h10C, 32'd100, 0, 0);
        bus(1, 32'h108, 32'd50, 0, 0);
        bus(1, 32'h110, 32'h3, 0, 0);
        n_checks++; if (timer_match !== 1'b0) begin n_fail++; $display("FAIL race_pre got %b exp 0", timer_match); end
        bus(1, 32'h108, 32'd100, 0, 0);
        bus(1, 32'h110, 32'h1, 0, 0);
        n_checks++; if (timer_match !== 1'b1) begin n_fail++; $display("FAIL race_set_wins got %b exp 1", timer_match); end
        bus(1, 32'h110, 32'h1, 0, 0);
        n_checks++; if (timer_match !== 1'b0) begin n_fail++; $display("FAIL race_clear got %b exp 0", timer_match); end
    endtask

    task automatic test_unmapped();
        bus(0, 0, 0, 1, 32'h100);
        n_checks++; if (dmem_rdata !== 32'h22) begin n_fail++; $display("FAIL unm_led_pre got %h exp 22", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h200);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL unm_rd got %h exp 0", dmem_rdata); end
        bus(1, 32'h200, 32'hFFFF_FFFF, 0, 0);
        n_checks++; if (leds !== 8'h22) begin n_fail++; $display("FAIL unm_wr_leds got %h exp 22", leds); end
        bus(0, 0, 0, 1, 32'h10C);
        n_checks++; if (dmem_rdata !== 32'd100) begin n_fail++; $display("FAIL unm_tcmp got %h exp 64", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h110);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL unm_status got %h exp 0", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h100);
        bus(0, 0, 0, 1, 32'h0FC);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL unm_below got %h exp 0", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h100);
        bus(0, 0, 0, 1, 32'h114);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL unm_above got %h exp 0", dmem_rdata); end
    endtask

    task automatic test_reset_mid();
        sw_in = 8'h81;
        repeat (4) step();
        rst = 1'b1;
        step();
        n_checks++; if (dut.u_deb.cnt_q !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt got %h exp 0", dut.u_deb.cnt_q); end
        n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL rmid_leds got %h exp 0", leds); end
        rst = 1'b0;
        bus(0, 0, 0, 1, 32'h104);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_sw got %h exp 0", dmem_rdata); end
        bus(0, 0, 0, 1, 32'h10C);
        n_checks++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_tcmp got %h exp 0", dmem_rdata); end
    endtask

    initial begin
        test_reset();
        test_led();
        test_same_cycle();
        test_glitch();
        test_debounce();
        test_timer();
        test_w1c_race();
        test_unmapped();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
